// File: rtl/rst_clk_seq_pkg.sv
// rtl/rst_clk_seq_pkg.sv - shared state encoding and constants for the reset/clock-enable sequencer
package rst_clk_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_HOLD      = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_SOFT_GATE = 3'd4,
    S_SOFT_HOLD = 3'd5,
    S_ACK       = 3'd6
  } state_e;

  localparam int SOFT_GATE_CYCLES = 2;

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - async-assert, sync-deassert reset synchronizer
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  output logic rst_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_clk_sequencer.sv
// rtl/rst_clk_sequencer.sv - ordered per-domain reset release and clock gating with soft-reset handshake
module rst_clk_sequencer
  import rst_clk_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_req,
  input  logic [NUM_DOMAINS-1:0] domain_mask,
  output logic                   soft_ack,
  output logic [NUM_DOMAINS-1:0] reset_n,
  output logic [NUM_DOMAINS-1:0] clk_en,
  output logic                   busy,
  output logic [2:0]             state_o
);

  localparam int MAXC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic rst_s;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i  (clk),
    .arst_i (reset),
    .rst_o  (rst_s)
  );

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_DOMAINS-1:0] mask_q, mask_d;
  logic [NUM_DOMAINS-1:0] reset_n_q, reset_n_d;
  logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d;
  logic                   armed_q, armed_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;

  // Lowest set mask bit, and next set bit above the current pointer.
  logic [PW-1:0] low_ptr, nxt_ptr;
  logic          nxt_found;

  always_comb begin
    low_ptr   = '0;
    nxt_ptr   = '0;
    nxt_found = 1'b0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (mask_q[i]) low_ptr = PW'(i);
    end
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (!nxt_found && mask_q[i] && (i > int'(ptr_q))) begin
        nxt_found = 1'b1;
        nxt_ptr   = PW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    mask_d    = mask_q;
    reset_n_d = reset_n_q;
    clk_en_d  = clk_en_q;
    ack_d     = 1'b0;
    armed_d   = soft_req ? armed_q : 1'b1;

    case (state_q)
      S_RESET: begin
        state_d  = S_HOLD;
        clk_en_d = '1;
        cnt_d    = CW'(HOLD_CYCLES - 1);
        ptr_d    = '0;
      end
      S_HOLD, S_RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          reset_n_d[ptr_q] = 1'b1;
          if (ptr_q == PW'(NUM_DOMAINS - 1)) begin
            state_d = S_RUN;
          end else begin
            state_d = S_RELEASE;
            ptr_d   = ptr_q + 1'b1;
            cnt_d   = CW'(STAGGER_CYCLES - 1);
          end
        end
      end
      S_RUN: begin
        if (soft_req && armed_q) begin
          armed_d = 1'b0;
          mask_d  = domain_mask;
          if (domain_mask == '0) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d  = S_SOFT_GATE;
            clk_en_d = clk_en_q & ~domain_mask;
            cnt_d    = CW'(SOFT_GATE_CYCLES - 1);
          end
        end
      end
      S_SOFT_GATE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = S_SOFT_HOLD;
          reset_n_d = reset_n_q & ~mask_q;
          clk_en_d  = clk_en_q | mask_q;
          cnt_d     = CW'(HOLD_CYCLES - 1);
          ptr_d     = low_ptr;
        end
      end
      S_SOFT_HOLD: begin
        // Unselected domains are skipped, so staggering only spaces selected ones.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          reset_n_d[ptr_q] = 1'b1;
          if (nxt_found) begin
            ptr_d = nxt_ptr;
            cnt_d = CW'(STAGGER_CYCLES - 1);
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end
        end
      end
      S_ACK:   state_d = S_RUN;
      default: state_d = S_RESET;
    endcase

    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      ptr_q     <= '0;
      mask_q    <= '0;
      reset_n_q <= '0;
      clk_en_q  <= '0;
      armed_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      reset_n_q <= reset_n_d;
      clk_en_q  <= clk_en_d;
      armed_q   <= armed_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign soft_ack = ack_q;
  assign reset_n  = reset_n_q;
  assign clk_en   = clk_en_q;
  assign busy     = busy_q;
  assign state_o  = state_q;

endmodule

// File: doc/rst_clk_sequencer.md
Name: rst_clk_sequencer

Overview:
Synthesizable reset/clock-enable controller for the APB UART subsystem. It takes one asynchronous system reset and produces ordered, synchronously released active-low resets and clock enables for NUM_DOMAINS sub-domains (e.g. APB regs, TX, RX). It also services a software soft-reset request over a req/ack handshake, limited to a selectable subset of domains.

Parameters:
NUM_DOMAINS, 3, number of reset/clock-enable domains; index 0 is released first.
SYNC_STAGES, 2, reset-deassert synchronizer depth (>=2).
HOLD_CYCLES, 16, cycles reset stays asserted with clocks running (>=1).
STAGGER_CYCLES, 4, cycles between consecutive domain releases (>=1).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high system reset
soft_req  input  1  level soft-reset request
domain_mask  input  NUM_DOMAINS  domains affected by soft reset; sampled on request acceptance
soft_ack  output  1  one-cycle pulse when soft reset completes
reset_n  output  NUM_DOMAINS  per-domain active-low reset
clk_en  output  NUM_DOMAINS  per-domain clock enable
busy  output  1  high whenever not in S_RUN
state_o  output  3  current FSM state encoding, for debug and monitoring

Behaviour:
- Reset synchronizer: rst_sync asserts asynchronously with reset and deasserts after SYNC_STAGES rising edges.
- While rst_sync is high, the state is S_RESET. Outputs in S_RESET: reset_n=0, clk_en=0, soft_ack=0, busy=1, mask register=0, counter=0.
- Reset asserted in any state takes effect immediately (asynchronous) with the outputs above. Any in-flight soft reset is abandoned and never acked.
- States: S_RESET, S_HOLD, S_RELEASE, S_RUN, S_SOFT_GATE, S_SOFT_HOLD, S_ACK.
- Power-up sequence. Define T0 as the first edge at which rst_sync is sampled low:
  - At T0: enter S_HOLD; clk_en for all domains = 1; reset_n stays 0.
  - reset_n[i] rises at edge T0+HOLD_CYCLES+i*STAGGER_CYCLES (state S_RELEASE between releases).
  - At the last release edge: state = S_RUN, busy = 0.
  - Defaults: reset_n[0..2] rise at T0+16, T0+20, T0+24.
- Soft reset accepted only when state = S_RUN, soft_req = 1 and the armed flag = 1.
  - armed clears on acceptance and sets again only after soft_req is sampled low. A request held high across ack is therefore not re-accepted.
  - soft_req is ignored in every other state (no queueing).
- Soft sequence, acceptance at edge E with latched mask M:
  - M == 0: no reset activity; state goes to S_ACK at E, soft_ack high for cycle E..E+1, back to S_RUN at E+1.
  - E: enter S_SOFT_GATE; clk_en[M] = 0, so clocks stop before reset asserts.
  - E+2: enter S_SOFT_HOLD; reset_n[M] = 0, clk_en[M] = 1.
  - E+2+HOLD_CYCLES: release the lowest set bit of M; each further set bit releases STAGGER_CYCLES later. Unset bits are skipped with no delay.
  - At the last release edge: enter S_ACK, soft_ack = 1 for exactly one cycle. Next edge: S_RUN, busy = 0.
  - Domains not in M keep reset_n = 1 and clk_en = 1 throughout.
- Only one counter: width $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1), reloaded at each phase start. The domain pointer is $clog2(NUM_DOMAINS) bits wide and must not wrap past NUM_DOMAINS-1.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package rst_clk_seq_pkg holds:
  - the state enum typedef (3-bit): S_RESET=0, S_HOLD=1, S_RELEASE=2, S_RUN=3, S_SOFT_GATE=4, S_SOFT_HOLD=5, S_ACK=6.
  - the SOFT_GATE_CYCLES=2 constant.
- One sub-module, rst_sync: async-assert/sync-deassert synchronizer parameterised by SYNC_STAGES.

Test Plan:
- Power-up, defaults: deassert reset. Required: no output change for 2 edges; reset_n = 3'b001/011/111 at T0+16/+20/+24; clk_en = 3'b111 from T0; busy falls at T0+24.
- Soft reset, mask 3'b101: accepted at E. Required: clk_en = 3'b010 at E..E+2; reset_n = 3'b010 from E+2; reset_n[0] rises at E+18, reset_n[2] at E+22; soft_ack high E+22..E+23; reset_n[1] never drops.
- Mask 3'b000: soft_ack pulses one cycle after acceptance; reset_n and clk_en never change.
- Held request: soft_req held high 50 cycles. Required: exactly one ack; drop soft_req for one cycle, raise again; second sequence starts.
- Reset mid-soft-sequence: assert reset at E+10. Required: reset_n=0, clk_en=0, soft_ack=0 immediately (same delta, no clock); full power-up sequence repeats; no ack ever emitted.
- soft_req during power-up at T0+5: ignored; no ack; state_o follows 1→2→3 only.
